pre_proc_hpf: RTL

//  G.729 pre-processing 2nd-order high-pass IIR (140 Hz cutoff, input scaled by 1/2).

---
 rtl/pre_proc_hpf.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pre_proc_hpf.sv
// Second-order high-pass pre-filter, one 16-bit sample per request, ITU basic-op exact.
// A single 32x16 multiply path is time-shared across the five taps by the sequencer.
module pre_proc_hpf (
    input  logic               mclk,
    input  logic               reset,
    input  logic               start,
    input  logic               init,
    input  logic signed [15:0] x_in,
    output logic               busy,
    output logic               done,
    output logic signed [15:0] y_out
);

    localparam int unsigned XW = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned SHL = 3;

    localparam logic signed [XW-1:0] A1 = 16'sd7807;
    localparam logic signed [XW-1:0] A2 = -16'sd3733;
    localparam logic signed [XW-1:0] B0 = 16'sd1899;
    localparam logic signed [XW-1:0] B1 = -16'sd3798;
    localparam logic signed [XW-1:0] B2 = 16'sd1899;

    localparam logic signed [AW-1:0] MAX32 = 32'sh7FFF_FFFF;
    localparam logic signed [AW-1:0] MIN32 = 32'sh8000_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_MY1, S_MY2, S_MX0, S_MX1, S_MX2, S_SHIFT, S_UPD, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [XW-1:0]  xs_q, xs_d, x1_q, x1_d, x2_q, x2_d;
    logic signed [AW-1:0]  y1_q, y1_d, y2_q, y2_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic signed [XW-1:0]  y_q, y_d;

    // Saturating 32-bit add (L_add).
    function automatic logic signed [AW-1:0] l_add(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b);
        logic signed [AW:0] s;
        s = (AW+1)'(a) + (AW+1)'(b);
        if (s[AW] != s[AW-1]) l_add = s[AW] ? MIN32 : MAX32;
        else                  l_add = s[AW-1:0];
    endfunction

    logic signed [AW-1:0] op32;
    logic signed [XW-1:0] coef, hi, lo;
    logic signed [AW-1:0] p_hi, p_lo, l_mult, lo_term, mpy, acc_mac, acc_shl, rnd;

    // Shared Mpy_32_16 path; x taps enter as x<<16 so the low half contributes nothing.
    always_comb begin
        op32 = '0;
        coef = '0;
        case (state_q)
            S_MY1:   begin op32 = y1_q;          coef = A1; end
            S_MY2:   begin op32 = y2_q;          coef = A2; end
            S_MX0:   begin op32 = {xs_q, 16'h0}; coef = B0; end
            S_MX1:   begin op32 = {x1_q, 16'h0}; coef = B1; end
            S_MX2:   begin op32 = {x2_q, 16'h0}; coef = B2; end
            default: begin op32 = '0;            coef = '0; end
        endcase
        hi      = op32[31:16];
        lo      = op32[15:0] >> 1;
        p_hi    = AW'(hi) * AW'(coef);
        p_lo    = AW'(lo) * AW'(coef);
        l_mult  = (p_hi == 32'sh4000_0000) ? MAX32 : (p_hi <<< 1);
        lo_term = (p_lo >>> 15) <<< 1;
        mpy     = l_add(l_mult, lo_term);
        acc_mac = l_add(acc_q, mpy);
        if (acc_q[31:28] == 4'h0 || acc_q[31:28] == 4'hF) acc_shl = acc_q <<< SHL;
        else                                              acc_shl = acc_q[31] ? MIN32 : MAX32;
        rnd     = l_add(acc_q, 32'sh0000_8000);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        xs_d    = xs_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (init) begin
                    x1_d = '0;
                    x2_d = '0;
                    y1_d = '0;
                    y2_d = '0;
                end
                if (start) begin
                    xs_d    = x_in;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_MY1;
                end
            end
            S_MY1:   begin acc_d = acc_mac; state_d = S_MY2;   end
            S_MY2:   begin acc_d = acc_mac; state_d = S_MX0;   end
            S_MX0:   begin acc_d = acc_mac; state_d = S_MX1;   end
            S_MX1:   begin acc_d = acc_mac; state_d = S_MX2;   end
            S_MX2:   begin acc_d = acc_mac; state_d = S_SHIFT; end
            S_SHIFT: begin acc_d = acc_shl; state_d = S_UPD;   end
            S_UPD: begin
                y2_d    = y1_q;
                y1_d    = acc_q;
                x2_d    = x1_q;
                x1_d    = xs_q;
                y_d     = XW'(rnd >>> 16);
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            xs_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            xs_q    <= xs_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign y_out = y_q;

endmodule
